// File: rtl/rv_traffic_checker.sv
// Ready/valid traffic generator and in-order checker.
// Sender and checker share a data LFSR sequence; stall LFSR shapes random traffic.
module rv_traffic_checker #(
    parameter int          DATA_W       = 8,
    parameter int          NUM_SEQUENCE = 16,
    parameter int          CNT_W        = 16,
    parameter int          TIMEOUT      = 1024,
    parameter logic [31:0] DATA_SEED    = 32'h1,
    parameter logic [15:0] STALL_SEED   = 16'hACE1,
    localparam int         SC_W         = $clog2(NUM_SEQUENCE + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              src_valid,
    output logic [DATA_W-1:0] src_data,
    input  logic              src_ready,
    input  logic              snk_valid,
    input  logic [DATA_W-1:0] snk_data,
    output logic              snk_ready,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [SC_W-1:0]   sent_count,
    output logic [SC_W-1:0]   recv_count,
    output logic [CNT_W-1:0]  error_count,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] M_RANDOM  = 2'd0;
    localparam logic [1:0] M_PERFECT = 2'd1;
    localparam logic [1:0] M_BUSY    = 2'd2;
    localparam logic [1:0] M_SLOW    = 2'd3;

    localparam logic [SC_W-1:0]  NS   = SC_W'(NUM_SEQUENCE);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(NUM_SEQUENCE / 2);

    function automatic logic [31:0] data_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    function automatic logic [15:0] stall_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        mode_q;
    logic              first_q;
    logic [31:0]       tx_lfsr, rx_lfsr;
    logic [15:0]       stall_lfsr;

    logic              start_run, in_run, stay_run;
    logic              src_xfer, snk_xfer, overflow, mismatch;
    logic              finish, expire, pending, remain;
    logic              valid_nxt, ready_nxt;
    logic [SC_W-1:0]   sent_nxt, recv_nxt;
    logic [CNT_W-1:0]  cyc_nxt;
    logic [31:0]       tx_nxt;

    always_comb begin
        start_run = start && (state_q != S_RUN);
        in_run    = (state_q == S_RUN);
        src_xfer  = src_valid && src_ready;
        snk_xfer  = snk_valid && snk_ready;
        overflow  = snk_xfer && (recv_count == NS);
        mismatch  = snk_xfer && !overflow
                    && (snk_data != rx_lfsr[DATA_W-1:0]);
        sent_nxt  = (src_xfer && sent_count != NS)
                    ? sent_count + 1'b1 : sent_count;
        recv_nxt  = (snk_xfer && !overflow)
                    ? recv_count + 1'b1 : recv_count;
        // The entry cycle only primes the registered handshakes.
        cyc_nxt   = (in_run && !first_q && cycle_count != '1)
                    ? cycle_count + 1'b1 : cycle_count;
        finish    = (recv_nxt == NS);
        expire    = (32'(cyc_nxt) >= 32'(TIMEOUT));
        stay_run  = in_run && !finish && !expire;
        pending   = src_valid && !src_ready;
        remain    = (sent_nxt != NS);
        tx_nxt    = src_xfer ? data_step(tx_lfsr) : tx_lfsr;
    end

    always_comb begin
        valid_nxt = 1'b0;
        ready_nxt = 1'b0;
        if (stay_run) begin
            if (pending)
                valid_nxt = 1'b1;
            else
                valid_nxt = remain
                    && (mode_q != M_RANDOM || stall_lfsr[0]);
            unique case (mode_q)
                M_RANDOM:  ready_nxt = stall_lfsr[1];
                M_PERFECT: ready_nxt = 1'b1;
                M_BUSY:    ready_nxt = (cyc_nxt >= HALF);
                M_SLOW:    ready_nxt = cyc_nxt[0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (finish || expire) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done = (state_q == S_DONE);
        pass = done && !timeout && (error_count == '0)
               && (recv_count == NS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= M_RANDOM;
            first_q     <= 1'b0;
            tx_lfsr     <= DATA_SEED;
            rx_lfsr     <= DATA_SEED;
            stall_lfsr  <= STALL_SEED;
            src_valid   <= 1'b0;
            src_data    <= '0;
            snk_ready   <= 1'b0;
            timeout     <= 1'b0;
            sent_count  <= '0;
            recv_count  <= '0;
            error_count <= '0;
            cycle_count <= '0;
        end else if (start_run) begin
            mode_q      <= mode;
            first_q     <= 1'b1;
            tx_lfsr     <= DATA_SEED;
            rx_lfsr     <= DATA_SEED;
            stall_lfsr  <= STALL_SEED;
            src_valid   <= 1'b0;
            src_data    <= '0;
            snk_ready   <= 1'b0;
            timeout     <= 1'b0;
            sent_count  <= '0;
            recv_count  <= '0;
            error_count <= '0;
            cycle_count <= '0;
        end else begin
            first_q <= 1'b0;
            if (in_run) begin
                stall_lfsr  <= stall_step(stall_lfsr);
                cycle_count <= cyc_nxt;
                if (expire && !finish)
                    timeout <= 1'b1;
            end
            tx_lfsr    <= tx_nxt;
            sent_count <= sent_nxt;
            recv_count <= recv_nxt;
            if (snk_xfer && !overflow)
                rx_lfsr <= data_step(rx_lfsr);
            if ((mismatch || overflow) && error_count != '1)
                error_count <= error_count + 1'b1;
            src_valid <= valid_nxt;
            snk_ready <= ready_nxt;
            // A pending beat keeps tx_nxt unchanged, so data holds too.
            src_data  <= valid_nxt ? tx_nxt[DATA_W-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_rv_traffic_checker.sv
// Directed bench for rv_traffic_checker: loopback, half buffer,
// corruption, mid-run reset and timeout scenarios.
module tb_rv_traffic_checker;

    localparam int DW = 8;
    localparam int SW = 5;
    localparam int CW = 16;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [1:0]    mode;
    logic          src_valid, src_ready;
    logic [DW-1:0] src_data;
    logic          snk_valid, snk_ready;
    logic [DW-1:0] snk_data;
    logic          done, pass, timeout;
    logic [SW-1:0] sent_count, recv_count;
    logic [CW-1:0] error_count, cycle_count;

    logic          t_start;
    logic          t_src_valid, t_snk_ready;
    logic [DW-1:0] t_src_data;
    logic          t_done, t_pass, t_timeout;
    logic [SW-1:0] t_sent, t_recv;
    logic [CW-1:0] t_err, t_cyc;

    logic          route;
    logic          corrupt;
    logic          hb_full;
    logic [DW-1:0] hb_data;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    int            viol;
    int            n_cmp;
    int            n_err;
    logic [DW-1:0] beats[$];

    rv_traffic_checker #(.DATA_W(DW), .NUM_SEQUENCE(16), .CNT_W(CW),
                         .TIMEOUT(1024)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready),
        .snk_valid(snk_valid), .snk_data(snk_data),
        .snk_ready(snk_ready),
        .done(done), .pass(pass), .timeout(timeout),
        .sent_count(sent_count), .recv_count(recv_count),
        .error_count(error_count), .cycle_count(cycle_count)
    );

    rv_traffic_checker #(.DATA_W(DW), .NUM_SEQUENCE(16), .CNT_W(CW),
                         .TIMEOUT(64)) tdut (
        .clk(clk), .reset_n(reset_n), .start(t_start),
        .mode(2'd1),
        .src_valid(t_src_valid), .src_data(t_src_data),
        .src_ready(1'b1),
        .snk_valid(1'b0), .snk_data(8'h00),
        .snk_ready(t_snk_ready),
        .done(t_done), .pass(t_pass), .timeout(t_timeout),
        .sent_count(t_sent), .recv_count(t_recv),
        .error_count(t_err), .cycle_count(t_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback (optionally corrupting beat 3) or a one-entry half buffer.
    always_comb begin
        if (route) begin
            src_ready = !hb_full;
            snk_valid = hb_full;
            snk_data  = hb_data;
        end else begin
            src_ready = snk_ready;
            snk_valid = src_valid;
            snk_data  = src_data
                ^ {7'd0, corrupt && (recv_count == 5'd2)};
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_full <= 1'b0;
            hb_data <= '0;
        end else if (route && !hb_full && src_valid) begin
            hb_full <= 1'b1;
            hb_data <= src_data;
        end else if (hb_full && snk_ready) begin
            hb_full <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (reset_n && src_valid && src_ready)
            beats.push_back(src_data);
        if (reset_n && prev_stall
            && (!src_valid || src_data != prev_data))
            viol <= viol + 1;
        prev_stall <= reset_n && src_valid && !src_ready;
        prev_data  <= src_data;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", {31'd0, done}, 32'd1);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        viol    = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        t_start = 1'b0;
        mode    = 2'd0;
        route   = 1'b0;
        corrupt = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_flags",
              {27'd0, src_valid, snk_ready, done, pass, timeout}, 32'd0);
        check("rst_data", {24'd0, src_data}, 32'd0);
        check("rst_cnt", {22'd0, sent_count, recv_count}, 32'd0);
        check("rst_err", {error_count, cycle_count}, 32'd0);
        reset_n = 1'b1;

        // PERFECT loopback.
        beats.delete();
        do_start(2'd1);
        check("lat_n", {31'd0, src_valid}, 32'd0);
        @(negedge clk);
        check("lat_n1", {31'd0, src_valid}, 32'd1);
        check("first_data", {24'd0, src_data}, 32'h01);
        wait_done(40);
        check("perf_cyc", {16'd0, cycle_count}, 32'd16);
        check("perf_pass", {31'd0, pass}, 32'd1);
        check("perf_err", {16'd0, error_count}, 32'd0);
        check("perf_sent", {27'd0, sent_count}, 32'd16);
        check("perf_beat1", {24'd0, beats[1]}, 32'h03);
        check("perf_beat2", {24'd0, beats[2]}, 32'h02);
        check("perf_beat4", {24'd0, beats[4]}, 32'h03);
        check("perf_nbeats", beats.size(), 32'd16);
        check("perf_out_idle", {30'd0, src_valid, snk_ready}, 32'd0);

        // BUSY_RECEIVER loopback.
        do_start(2'd2);
        repeat (9) @(negedge clk);
        check("busy_cyc8", {16'd0, cycle_count}, 32'd8);
        check("busy_nosend", {27'd0, sent_count}, 32'd0);
        check("busy_hold", {23'd0, src_valid, src_data}, 32'h101);
        wait_done(60);
        check("busy_cyc", {16'd0, cycle_count}, 32'd24);
        check("busy_pass", {31'd0, pass}, 32'd1);

        // SLOW_RECEIVER loopback: one beat every other cycle.
        do_start(2'd3);
        wait_done(80);
        check("slow_cyc", {16'd0, cycle_count}, 32'd32);
        check("slow_pass", {31'd0, pass}, 32'd1);

        // RANDOM through a half buffer.
        route = 1'b1;
        do_start(2'd0);
        wait_done(2000);
        check("rnd_sent", {27'd0, sent_count}, 32'd16);
        check("rnd_recv", {27'd0, recv_count}, 32'd16);
        check("rnd_pass", {31'd0, pass}, 32'd1);
        route = 1'b0;

        // Corrupted third beat.
        corrupt = 1'b1;
        do_start(2'd1);
        wait_done(40);
        check("cor_err", {16'd0, error_count}, 32'd1);
        check("cor_pass", {31'd0, pass}, 32'd0);
        check("cor_recv", {27'd0, recv_count}, 32'd16);
        corrupt = 1'b0;

        // Reset in the middle of a PERFECT run.
        do_start(2'd1);
        for (int i = 0; i < 40 && sent_count != 5'd5; i++)
            @(negedge clk);
        check("mid_sent5", {27'd0, sent_count}, 32'd5);
        reset_n = 1'b0;
        #1;
        check("mid_flags",
              {27'd0, src_valid, snk_ready, done, pass, timeout}, 32'd0);
        check("mid_cnt", {22'd0, sent_count, recv_count}, 32'd0);
        check("mid_data", {24'd0, src_data}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_start(2'd1);
        @(negedge clk);
        check("mid_first", {23'd0, src_valid, src_data}, 32'h101);
        wait_done(40);
        check("mid_pass", {31'd0, pass}, 32'd1);

        // Timeout with a receiver that never answers.
        @(negedge clk);
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        for (int i = 0; i < 200 && !t_done; i++)
            @(negedge clk);
        check("to_done", {31'd0, t_done}, 32'd1);
        check("to_flag", {31'd0, t_timeout}, 32'd1);
        check("to_sent", {27'd0, t_sent}, 32'd16);
        check("to_recv", {27'd0, t_recv}, 32'd0);
        check("to_pass", {31'd0, t_pass}, 32'd0);
        check("to_cyc", {16'd0, t_cyc}, 32'd64);
        check("to_idle", {30'd0, t_src_valid, t_snk_ready}, 32'd0);

        check("src_stable", viol, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
